// File: rtl/cocofdc_pkg.sv
// Shared types and legal parameter bounds for the CoCo FDC bus arbiter.
package cocofdc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOff,
    StHalt,
    StGrant,
    StRel
  } arb_state_e;

  localparam int unsigned SettleMin   = 1;
  localparam int unsigned SettleMax   = 14;
  localparam int unsigned MaxRetryMin = 1;
  localparam int unsigned MaxRetryMax = 15;
  localparam int unsigned NregMax     = 16;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cocofdc_regint.sv
// Per-register write-pending latch; a set and a clear on the same bit leave the bit set.
module cocofdc_regint
  import cocofdc_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic            eclk_i,
  input  logic            reset_ni,
  input  logic [NREG-1:0] set_i,
  input  logic [NREG-1:0] clr_i,
  output logic [NREG-1:0] pend_o
);

  logic [NREG-1:0] pend_d, pend_q;

  always_comb begin
    pend_d = (pend_q & ~clr_i) | set_i;
  end

  always_ff @(posedge eclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/cocofdc_bus_arb.sv
// CoCo HALT-handshake arbiter granting the SRAM/EEPROM bus to the AVR.
// Register-write interrupts are built only when COCOFDC_REGINT_EN is defined.
module cocofdc_bus_arb
  import cocofdc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned SETTLE    = 3,
  parameter int unsigned RETRY_WIN = 16,
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned NREG      = 4
) (
  input  logic              eclk,
  input  logic              reset_n,
  input  logic              c_power,
  input  logic [ADDR_W-1:0] c_addrbus,
  input  logic              c_rw,
  input  logic              cts_n,
  input  logic              scs_n,
  input  logic              a_busreq,
  input  logic [ADDR_W:0]   a_addrbus,
  input  logic              a_rw,
  input  logic              a_een_n,
  input  logic [NREG-1:0]   a_regint_clr,
  output logic              halt_drv,
  output logic              a_busmaster,
  output logic              a_fault,
  output logic [NREG-1:0]   a_regint,
  output logic [ADDR_W-1:0] m_addrbus,
  output logic              m_rw,
  output logic              m_oe_n,
  output logic              s_cs_n,
  output logic              e_cs_n
);

  localparam int unsigned CntW   = $clog2(RETRY_WIN);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam int unsigned IdxW   = (NREG > 1) ? $clog2(NREG) : 1;

  if (SETTLE < SettleMin || SETTLE > SettleMax || RETRY_WIN <= SETTLE ||
      MAX_RETRY < MaxRetryMin || MAX_RETRY > MaxRetryMax ||
      !is_pow2(NREG) || NREG > NregMax) begin : g_bad_param
    $error("cocofdc_bus_arb: illegal parameter set");
  end

  arb_state_e        state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [RetryW-1:0] retry_d, retry_q;
  logic              fault_d, fault_q;
  logic              halt_d, halt_q;
  logic              busmaster_d, busmaster_q;
  logic              bus_idle;

  assign bus_idle = cts_n & scs_n;

  always_ff @(posedge eclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      retry_q     <= '0;
      fault_q     <= 1'b0;
      halt_q      <= 1'b0;
      busmaster_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      fault_q     <= fault_d;
      halt_q      <= halt_d;
      busmaster_q <= busmaster_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (!a_busreq) fault_d = 1'b0;
        if (!c_power) state_d = StOff;
        else if (a_busreq && !fault_q) state_d = StHalt;
      end
      StOff: begin
        if (c_power) state_d = StIdle;
      end
      StHalt: begin
        if (!c_power) begin
          state_d = StOff;
          retry_d = '0;
        end else if (!a_busreq) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(SETTLE - 1) && bus_idle) begin
          state_d = StGrant;
        end else if (cnt_q == CntW'(RETRY_WIN - 1)) begin
          // Retry is zeroed on fault so the next request starts a fresh budget.
          if (retry_q == RetryW'(MAX_RETRY - 1)) begin
            state_d = StIdle;
            fault_d = 1'b1;
            retry_d = '0;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGrant: begin
        if (!c_power) begin
          state_d = StOff;
          retry_d = '0;
        end else if (!a_busreq) begin
          state_d = StRel;
        end
      end
      StRel: begin
        state_d = c_power ? StIdle : StOff;
        retry_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    halt_d      = 1'b0;
    busmaster_d = 1'b0;
    case (state_d)
      StHalt, StRel: halt_d = 1'b1;
      StGrant: begin
        halt_d      = 1'b1;
        busmaster_d = 1'b1;
      end
      StOff:   busmaster_d = 1'b1;
      default: ;
    endcase
  end

  assign halt_drv    = halt_q;
  assign a_busmaster = busmaster_q;
  assign a_fault     = fault_q;

  always_comb begin
    if (busmaster_q) begin
      m_addrbus = a_addrbus[ADDR_W-1:0];
      m_rw      = a_rw;
      m_oe_n    = a_een_n;
      s_cs_n    = a_addrbus[ADDR_W];
      e_cs_n    = ~a_addrbus[ADDR_W];
    end else begin
      m_addrbus = c_addrbus;
      m_rw      = c_rw;
      m_oe_n    = bus_idle | ~eclk;
      s_cs_n    = scs_n;
      e_cs_n    = cts_n;
    end
  end

`ifdef COCOFDC_REGINT_EN
  logic [NREG-1:0] regint_set;
  logic [IdxW-1:0] reg_idx;

  assign reg_idx = c_addrbus[IdxW-1:0];

  always_comb begin
    regint_set = '0;
    if (!scs_n && !c_rw && c_power) regint_set[reg_idx] = 1'b1;
  end

  cocofdc_regint #(
    .NREG(NREG)
  ) u_regint (
    .eclk_i  (eclk),
    .reset_ni(reset_n),
    .set_i   (regint_set),
    .clr_i   (a_regint_clr),
    .pend_o  (a_regint)
  );
`else
  logic unused_regint_clr;
  assign unused_regint_clr = ^a_regint_clr;
  assign a_regint          = '0;
`endif

endmodule
